card_sprite_reader: RTL and testbench

CARD_SPRITE_READER -- requirements
Module: card_sprite_reader

---
 rtl/card_pkg.sv | 20 ++
 rtl/card_hit_addr.sv | 47 ++++
 rtl/card_sprite_reader.sv | 103 ++++++++++
 tb/tb_card_sprite_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants and types for the card sprite reader.
//   CARD_W / CARD_H : default sprite size in pixels (their product is the 512-word memory)
//   TRANSPARENT     : default see-through colour code
//   SCREEN_W/H      : visible area limits, used to clip overhanging cards
//   pos_state_e     : position-update FSM states
package card_pkg;

    localparam int unsigned CARD_W      = 16;
    localparam int unsigned CARD_H      = 32;
    localparam logic [2:0]  TRANSPARENT = 3'b000;

    localparam int unsigned SCREEN_W = 256;
    localparam int unsigned SCREEN_H = 240;

    typedef enum logic {
        IDLE,
        PENDING
    } pos_state_e;

endpackage

// File: rtl/card_hit_addr.sv
// Combinational hit test and sprite-memory address generation.
//   pixelX, pixelY, videoOn    : current raster position
//   activeX, activeY, activeEn : card position in effect for this frame
//   hit                        : pixel lies inside the visible part of the card
//   addr                       : row-major offset of the pixel inside the card
module card_hit_addr
    import card_pkg::*;
#(
    parameter int unsigned CARD_W = card_pkg::CARD_W,
    parameter int unsigned CARD_H = card_pkg::CARD_H
) (
    input  logic [8:0] pixelX,
    input  logic [7:0] pixelY,
    input  logic       videoOn,
    input  logic [7:0] activeX,
    input  logic [7:0] activeY,
    input  logic       activeEn,
    output logic       hit,
    output logic [8:0] addr
);

    // 10-bit compares so activeX+CARD_W never wraps past 255.
    logic [9:0] px, py, ax, ay;
    logic       inX, inY, onScreen;
    logic [8:0] dx, dy;

    always_comb begin
        px = {1'b0, pixelX};
        py = {2'b00, pixelY};
        ax = {2'b00, activeX};
        ay = {2'b00, activeY};

        inX      = (px >= ax) && (px < ax + 10'(CARD_W));
        inY      = (py >= ay) && (py < ay + 10'(CARD_H));
        // Explicit clip: a card overhanging the right/bottom edge must not
        // leak into blanking even if videoOn is misbehaving.
        onScreen = (px < 10'(SCREEN_W)) && (py < 10'(SCREEN_H));

        hit = videoOn & activeEn & inX & inY & onScreen;

        // Only meaningful when hit; offsets then fit comfortably in 9 bits.
        dx   = pixelX - {1'b0, activeX};
        dy   = {1'b0, pixelY} - {1'b0, activeY};
        addr = dy * 9'(CARD_W) + dx;
    end

endmodule

// File: rtl/card_sprite_reader.sv
// Card sprite reader: double-buffered card position plus a two-stage pixel
// pipeline that fetches sprite colours from an external 512-word memory.
//   clock, resetN         : system clock, synchronous active-low reset
//   pixelX/pixelY/videoOn : raster position (stage 0)
//   frameStart            : start of vertical blanking; applies a pending position
//   cardX/cardY/cardEn    : requested position, captured on posLoad
//   RE, rAddr             : memory read request (stage 1)
//   dataIn                : memory data for the stage-1 request
//   pixelOut, pixelValid  : sprite colour and opacity (stage 2)
//   posPending            : a captured position awaits frameStart
// CARD_W*CARD_H must equal 512 to match the memory.
module card_sprite_reader
    import card_pkg::*;
#(
    parameter int unsigned CARD_W      = card_pkg::CARD_W,
    parameter int unsigned CARD_H      = card_pkg::CARD_H,
    parameter logic [2:0]  TRANSPARENT = card_pkg::TRANSPARENT
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [8:0] pixelX,
    input  logic [7:0] pixelY,
    input  logic       videoOn,
    input  logic       frameStart,
    input  logic [7:0] cardX,
    input  logic [7:0] cardY,
    input  logic       cardEn,
    input  logic       posLoad,
    output logic       RE,
    output logic [8:0] rAddr,
    input  logic [2:0] dataIn,
    output logic [2:0] pixelOut,
    output logic       pixelValid,
    output logic       posPending
);

    pos_state_e state;
    logic [7:0] pendX, pendY, activeX, activeY;
    logic       pendEn, activeEn;
    logic       hit;
    logic [8:0] addr;

    card_hit_addr #(
        .CARD_W (CARD_W),
        .CARD_H (CARD_H)
    ) u_hit_addr (
        .pixelX   (pixelX),
        .pixelY   (pixelY),
        .videoOn  (videoOn),
        .activeX  (activeX),
        .activeY  (activeY),
        .activeEn (activeEn),
        .hit      (hit),
        .addr     (addr)
    );

    assign posPending = (state == PENDING);

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state      <= IDLE;
            pendX      <= '0;
            pendY      <= '0;
            pendEn     <= 1'b0;
            activeX    <= '0;
            activeY    <= '0;
            activeEn   <= 1'b0;
            RE         <= 1'b0;
            rAddr      <= '0;
            pixelOut   <= '0;
            pixelValid <= 1'b0;
        end else begin
            // Active registers only change on frameStart, so a frame never tears.
            if (posLoad && frameStart) begin
                activeX  <= cardX;
                activeY  <= cardY;
                activeEn <= cardEn;
                state    <= IDLE;
            end else if (posLoad) begin
                pendX  <= cardX;
                pendY  <= cardY;
                pendEn <= cardEn;
                state  <= PENDING;
            end else if (frameStart && state == PENDING) begin
                activeX  <= pendX;
                activeY  <= pendY;
                activeEn <= pendEn;
                state    <= IDLE;
            end

            // Stage 1: RE doubles as the stage-1 hit flag.
            RE <= hit;
            if (hit) begin
                rAddr <= addr;
            end

            // Stage 2
            pixelOut   <= RE ? dataIn : 3'b000;
            pixelValid <= RE && (dataIn != TRANSPARENT);
        end
    end

endmodule

// File: tb/tb_card_sprite_reader.sv
module tb_card_sprite_reader;

    logic       clock = 1'b0;
    logic       resetN;
    logic [8:0] pixelX;
    logic [7:0] pixelY;
    logic       videoOn;
    logic       frameStart;
    logic [7:0] cardX;
    logic [7:0] cardY;
    logic       cardEn;
    logic       posLoad;
    logic       RE;
    logic [8:0] rAddr;
    logic [2:0] dataIn;
    logic [2:0] pixelOut;
    logic       pixelValid;
    logic       posPending;

    int nvec  = 0;
    int nfail = 0;

    // Sprite memory: word i = (i*5) mod 8, so word 0 = 0 (transparent), word 1 = 5.
    logic [2:0] mem [512];
    assign dataIn = mem[rAddr];

    always #5 clock = ~clock;

    card_sprite_reader dut (
        .clock      (clock),
        .resetN     (resetN),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .videoOn    (videoOn),
        .frameStart (frameStart),
        .cardX      (cardX),
        .cardY      (cardY),
        .cardEn     (cardEn),
        .posLoad    (posLoad),
        .RE         (RE),
        .rAddr      (rAddr),
        .dataIn     (dataIn),
        .pixelOut   (pixelOut),
        .pixelValid (pixelValid),
        .posPending (posPending)
    );

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic       von;
        logic       re;
        logic [8:0] addr;
        logic [2:0] out;
        logic       valid;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One isolated pixel: RE/rAddr after one cycle, pixelOut/pixelValid after two.
    task automatic apply_vec(input vec_t v, input string tag);
        pixelX  = v.x;
        pixelY  = v.y;
        videoOn = v.von;
        step();
        check({tag, " RE"}, 32'(RE), 32'(v.re));
        if (v.re) check({tag, " rAddr"}, 32'(rAddr), 32'(v.addr));
        videoOn = 1'b0;
        step();
        check({tag, " pixelOut"}, 32'(pixelOut), 32'(v.out));
        check({tag, " pixelValid"}, 32'(pixelValid), 32'(v.valid));
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            apply_vec(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic hit_chk(input int x, input int y, input logic exp_re, input int exp_addr,
                           input string tag);
        vec_t v;
        v.x = 9'(x); v.y = 8'(y); v.von = 1'b1; v.re = exp_re; v.addr = 9'(exp_addr);
        v.out   = exp_re ? mem[exp_addr] : 3'b000;
        v.valid = exp_re && (mem[exp_addr] != 3'b000);
        apply_vec(v, tag);
    endtask

    task automatic load_pos(input int x, input int y, input logic en, input logic fs);
        cardX = 8'(x); cardY = 8'(y); cardEn = en; posLoad = 1'b1; frameStart = fs;
        step();
        posLoad = 1'b0; frameStart = 1'b0;
    endtask

    task automatic frame_pulse();
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 3'((i * 5) % 8);

        // Card at (10,20)
        vecs[0]  = '{x: 10,  y: 20,  von: 1, re: 1, addr: 0,   out: 3'd0, valid: 0};
        vecs[1]  = '{x: 11,  y: 20,  von: 1, re: 1, addr: 1,   out: 3'd5, valid: 1};
        vecs[2]  = '{x: 25,  y: 51,  von: 1, re: 1, addr: 511, out: 3'd3, valid: 1};
        vecs[3]  = '{x: 26,  y: 20,  von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[4]  = '{x: 9,   y: 20,  von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[5]  = '{x: 10,  y: 52,  von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[6]  = '{x: 17,  y: 35,  von: 1, re: 1, addr: 247, out: 3'd3, valid: 1};
        vecs[7]  = '{x: 10,  y: 20,  von: 0, re: 0, addr: 0,   out: 3'd0, valid: 0};
        // Card at (250,230): clipped at the screen edge
        vecs[8]  = '{x: 255, y: 239, von: 1, re: 1, addr: 149, out: 3'd1, valid: 1};
        vecs[9]  = '{x: 250, y: 230, von: 1, re: 1, addr: 0,   out: 3'd0, valid: 0};
        vecs[10] = '{x: 256, y: 239, von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[11] = '{x: 265, y: 239, von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[12] = '{x: 255, y: 240, von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[13] = '{x: 250, y: 255, von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};
        vecs[14] = '{x: 251, y: 231, von: 1, re: 1, addr: 17,  out: 3'd5, valid: 1};
        vecs[15] = '{x: 249, y: 239, von: 1, re: 0, addr: 0,   out: 3'd0, valid: 0};

        resetN = 1'b0; pixelX = '0; pixelY = '0; videoOn = 1'b0; frameStart = 1'b0;
        cardX = '0; cardY = '0; cardEn = 1'b0; posLoad = 1'b0;
        step();
        step();
        check("reset RE", 32'(RE), 0);
        check("reset rAddr", 32'(rAddr), 0);
        check("reset pixelOut", 32'(pixelOut), 0);
        check("reset pixelValid", 32'(pixelValid), 0);
        check("reset posPending", 32'(posPending), 0);
        resetN = 1'b1;
        step();

        // No card enabled yet
        hit_chk(0, 0, 1'b0, 0, "no card");

        load_pos(10, 20, 1'b1, 1'b0);
        check("load posPending", 32'(posPending), 1);
        frame_pulse();
        check("apply posPending", 32'(posPending), 0);
        run_vecs(0, 7, "card10_20");

        // Back-to-back pixels: one per cycle, 2-cycle latency
        pixelX = 9'd10; pixelY = 8'd20; videoOn = 1'b1;
        step();
        pixelX = 9'd11;
        step();
        check("b2b rAddr", 32'(rAddr), 1);
        check("b2b first pixelValid", 32'(pixelValid), 0);
        check("b2b first pixelOut", 32'(pixelOut), 0);
        videoOn = 1'b0;
        step();
        check("b2b second pixelValid", 32'(pixelValid), 1);
        check("b2b second pixelOut", 32'(pixelOut), 5);

        load_pos(250, 230, 1'b1, 1'b0);
        frame_pulse();
        run_vecs(8, 15, "clip");

        // Deferred update: old position stays live until frameStart
        load_pos(40, 20, 1'b1, 1'b0);
        check("defer posPending", 32'(posPending), 1);
        hit_chk(250, 230, 1'b1, 0, "defer old hit");
        hit_chk(40, 20, 1'b0, 0, "defer new miss");
        check("defer posPending held", 32'(posPending), 1);
        frame_pulse();
        check("defer posPending clr", 32'(posPending), 0);
        hit_chk(40, 20, 1'b1, 0, "defer new hit");
        hit_chk(250, 230, 1'b0, 0, "defer old miss");

        // posLoad and frameStart together apply immediately
        load_pos(7, 20, 1'b1, 1'b1);
        check("same posPending", 32'(posPending), 0);
        hit_chk(7, 20, 1'b1, 0, "same hit");
        hit_chk(40, 20, 1'b0, 0, "same old miss");

        // frameStart while idle changes nothing
        frame_pulse();
        check("idle fs posPending", 32'(posPending), 0);
        hit_chk(8, 21, 1'b1, 17, "idle fs hit");

        // Later posLoad overwrites the pending value
        load_pos(100, 20, 1'b1, 1'b0);
        load_pos(120, 20, 1'b1, 1'b0);
        frame_pulse();
        hit_chk(120, 20, 1'b1, 0, "overwrite hit");
        hit_chk(100, 20, 1'b0, 0, "overwrite miss");

        // Disabled card never hits
        load_pos(120, 20, 1'b0, 1'b1);
        hit_chk(121, 21, 1'b0, 0, "disabled miss");
        load_pos(120, 20, 1'b1, 1'b1);

        // Reset in the middle of the card
        pixelX = 9'd125; pixelY = 8'd21; videoOn = 1'b1;
        step();
        check("midreset pre RE", 32'(RE), 1);
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        check("midreset RE", 32'(RE), 0);
        check("midreset rAddr", 32'(rAddr), 0);
        check("midreset pixelOut", 32'(pixelOut), 0);
        check("midreset pixelValid", 32'(pixelValid), 0);
        check("midreset posPending", 32'(posPending), 0);
        step();
        check("postreset RE", 32'(RE), 0);
        step();
        check("postreset pixelValid", 32'(pixelValid), 0);
        frame_pulse();
        hit_chk(125, 21, 1'b0, 0, "postreset fs miss");
        load_pos(120, 20, 1'b1, 1'b0);
        frame_pulse();
        hit_chk(125, 21, 1'b1, 21, "postreset reload hit");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
